fb_scanout: RTL
===============

# fb_scanout

Video scanout controller for the framebuffer's byte-wide read port (port B). It generates 640x480@60 raster timing and walks a 128x64, 8-bit-per-pixel source image, magnified 4x and centred in the active area. It drives the framebuffer's `addr_b`, realigns the returned `q_b` byte with delayed sync and enable signals, and outputs pixels for the video encoder. It also flags vertical blanking so the CPU can update port A without tearing.

## Interface
Parameters:
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing, in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing, in lines.
- `SRC_W` 128, `SRC_H` 64: source image size. `SRC_W*SRC_H` ≤ 2^`ADDR_WIDTH`.
- `SCALE_LOG2` 2: magnification is 2^`SCALE_LOG2` in both axes.
- `X_OFS` 64, `Y_OFS` 112: top-left corner of the window in active coordinates.
- `ADDR_WIDTH` 13: width of the framebuffer byte address.

Ports:
- `clk` in 1: system clock, shared with the framebuffer.
- `reset` in 1: synchronous, active-high.
- `pix_en` in 1: pixel-clock enable. All timing advances only on cycles where it is high.
- `addr_b` out `ADDR_WIDTH`: framebuffer read address (registered).
- `q_b` in 8: framebuffer read data. It is valid one `clk` after `addr_b` changes.
- `hsync`, `vsync` out 1: active-low syncs.
- `de` out 1: display enable, high in the active area.
- `pixel` out 8: pixel byte. It is 0 whenever `de` is low.
- `vblank` out 1: high while the vertical counter is at or past `V_ACTIVE`.
- `frame_start` out 1: one-tick pulse coincident with the first `de` pixel of each frame.

## Operation
- Counters: `h_cnt` runs 0..H_TOTAL-1 and `v_cnt` runs 0..V_TOTAL-1. H_TOTAL = 800 and V_TOTAL = 525 with the default parameters.
- `h_cnt` increments on each `pix_en`. At H_TOTAL-1 it wraps to 0 and `v_cnt` increments; `v_cnt` wraps at V_TOTAL-1.
- Counter-derived timing:
  - Active area: h < H_ACTIVE and v < V_ACTIVE.
  - hsync is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is decoded the same way from `v_cnt`.
- Window: the window is active when X_OFS ≤ h < X_OFS + SRC_W<<SCALE_LOG2 and the matching condition holds for v.
- Source coordinates: sx = (h−X_OFS)>>SCALE_LOG2 and sy = (v−Y_OFS)>>SCALE_LOG2. They come from sub-counters; no dividers or multipliers are used.
  - The line base address advances by SRC_W each time the line sub-counter wraps.
  - Address = base + sx.
- Outside the window, `addr_b` holds its last value and the pixel source is the border value.
- Pipeline, two `pix_en` ticks deep:
  - Stage 1: `addr_b`, window flag, and sync/de decode are registered from the counters.
  - Stage 2: `pixel`, `hsync`, `vsync` and `de` are registered. `pixel` takes `q_b` if the stage-1 window flag is set, the border value otherwise, and 0 when de is low.
- Reset values: counters 0, `addr_b` 0, `hsync`/`vsync` 1, `de` 0, `pixel` 0, `vblank` 0, `frame_start` 0.
- A reset asserted mid-frame restarts at h=v=0 on the next cycle, and the pipeline is flushed to the reset values.

## Timing
- Output latency is 2 `pix_en` ticks from counter state to `hsync`/`vsync`/`de`/`pixel`. All of these stay mutually aligned.
- The block requires only that `pix_en` ticks are at least 1 `clk` apart; every cycle is allowed. `addr_b` changes only on a tick, so `q_b` has settled before the next tick samples it.
- `vblank` is registered from `v_cnt`. It rises at the stage-2 output of line V_ACTIVE, pixel 0, and falls at the stage-2 output of line 0, pixel 0.
- `frame_start` is high for exactly one tick, the same tick on which `de` first goes high with h=v=0. Between ticks it holds.
- Every output holds its value on cycles where `pix_en` is low.

## Configuration
- `FB_SCANOUT_BORDER_EN` defined: adds an input port `border` (8 bits). In-`de`, out-of-window pixels output `border`, sampled at stage 2.
- `FB_SCANOUT_BORDER_EN` undefined: the port is absent and the border value is constant 0.

## Structure
- Shared package `video_pkg` holds:
  - the default 640x480 timing constants;
  - H_TOTAL and V_TOTAL derivations;
  - a `video_timing_t` struct of {hsync, vsync, de}.
- One sub-module, `video_timing`: h/v counters, sync/de/vblank decode, and the raw counter outputs. `fb_scanout` adds the window, addressing, pipeline and border logic.

## Test plan
- Reset, then `pix_en` held high for 420000 cycles. Expected response:
  - 800 ticks between hsync falls; `hsync` low for 96 ticks;
  - `vsync` low for 2 lines per 525;
  - `de` high for 640x480 ticks per frame.
- Framebuffer model preloaded with byte = address[7:0]. Expected response:
  - at output (h=64, v=112) pixel=0x00;
  - at (67,112) pixel=0x00;
  - at (68,112) pixel=0x01;
  - at (64,116) pixel=0x80 (address 128);
  - at (575,367) address 8191 gives pixel=0xFF.
- `pix_en` asserted every 4th `clk`: the pixel stream and sync spacing are identical to the continuous run, measured in ticks.
- Border, with `FB_SCANOUT_BORDER_EN` and `border`=0x5A:
  - at (10,10) pixel=0x5A;
  - at (700,10), where `de` is low, pixel=0x00;
  - without the macro, (10,10) gives 0x00.
- `reset` pulsed at (h=300, v=200): the next outputs follow the reset values, and `frame_start` pulses 2 ticks after the restart.
- `vblank` rises on the tick after the last active pixel of line 479. `frame_start` occurs exactly once per 420000 ticks.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared raster-timing definitions for the scanout path.
//   - Default 640x480@60 horizontal/vertical timing constants.
//   - H_TOTAL / V_TOTAL derivations for the defaults.
//   - video_timing_t: {hsync, vsync, de} bundle (syncs active-low).
//   - cnt_width(): counter width needed to hold 0..total-1.
package video_pkg;

    localparam int unsigned H_ACTIVE_DEFAULT = 640;
    localparam int unsigned H_FP_DEFAULT     = 16;
    localparam int unsigned H_SYNC_DEFAULT   = 96;
    localparam int unsigned H_BP_DEFAULT     = 48;
    localparam int unsigned V_ACTIVE_DEFAULT = 480;
    localparam int unsigned V_FP_DEFAULT     = 10;
    localparam int unsigned V_SYNC_DEFAULT   = 2;
    localparam int unsigned V_BP_DEFAULT     = 33;

    localparam int unsigned H_TOTAL_DEFAULT =
        H_ACTIVE_DEFAULT + H_FP_DEFAULT + H_SYNC_DEFAULT + H_BP_DEFAULT;
    localparam int unsigned V_TOTAL_DEFAULT =
        V_ACTIVE_DEFAULT + V_FP_DEFAULT + V_SYNC_DEFAULT + V_BP_DEFAULT;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } video_timing_t;

    // Idle / reset state of the timing bundle: syncs released, display off.
    localparam video_timing_t TIMING_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

    function automatic int unsigned cnt_width(input int unsigned total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/video_timing.sv
// video_timing: horizontal/vertical raster counters with combinational decode.
// Ports:
//   i_clk, i_reset  - clock, synchronous active-high reset
//   i_pix_en        - pixel-clock enable; counters advance only when high
//   o_h_cnt/o_v_cnt - raw counter values
//   o_timing        - {hsync, vsync, de} decoded from the current counters
//   o_vblank        - high while v_cnt >= V_ACTIVE
module video_timing
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int unsigned H_FP     = H_FP_DEFAULT,
    parameter int unsigned H_SYNC   = H_SYNC_DEFAULT,
    parameter int unsigned H_BP     = H_BP_DEFAULT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int unsigned V_FP     = V_FP_DEFAULT,
    parameter int unsigned V_SYNC   = V_SYNC_DEFAULT,
    parameter int unsigned V_BP     = V_BP_DEFAULT,
    parameter int unsigned HCNT_W   = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VCNT_W   = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_pix_en,
    output logic [HCNT_W-1:0]   o_h_cnt,
    output logic [VCNT_W-1:0]   o_v_cnt,
    output video_timing_t       o_timing,
    output logic                o_vblank
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT_END  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_SYNC_BEG = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] H_SYNC_END = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] V_LAST     = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT_END  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_SYNC_BEG = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] V_SYNC_END = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCNT_W-1:0] r_h_cnt;
    logic [VCNT_W-1:0] r_v_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_pix_en) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                if (r_v_cnt == V_LAST) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + VCNT_W'(1);
                end
            end else begin
                r_h_cnt <= r_h_cnt + HCNT_W'(1);
            end
        end
    end

    always_comb begin
        o_timing       = TIMING_IDLE;
        o_timing.de    = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
        o_timing.hsync = !((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END));
        o_timing.vsync = !((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END));
        o_vblank       = (r_v_cnt >= V_ACT_END);
    end

    assign o_h_cnt = r_h_cnt;
    assign o_v_cnt = r_v_cnt;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: scans a SRC_W x SRC_H 8bpp framebuffer out through its byte read
// port, magnified 2^SCALE_LOG2 and placed at (X_OFS, Y_OFS) in the active area.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   pix_en       - pixel-clock enable (one tick per pixel)
//   addr_b       - registered framebuffer read address
//   q_b          - framebuffer read data, settled within one clk of addr_b
//   border       - border pixel value (only with FB_SCANOUT_BORDER_EN)
//   hsync, vsync - active-low syncs; de - display enable; pixel - output byte
//   vblank       - vertical blanking flag, aligned with the pixel stream
//   frame_start  - one-tick pulse on the first displayed pixel of a frame
// Build option: define FB_SCANOUT_BORDER_EN to add the border input; otherwise
// out-of-window pixels are 0.
module fb_scanout
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEFAULT,
    parameter int unsigned H_FP       = H_FP_DEFAULT,
    parameter int unsigned H_SYNC     = H_SYNC_DEFAULT,
    parameter int unsigned H_BP       = H_BP_DEFAULT,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEFAULT,
    parameter int unsigned V_FP       = V_FP_DEFAULT,
    parameter int unsigned V_SYNC     = V_SYNC_DEFAULT,
    parameter int unsigned V_BP       = V_BP_DEFAULT,
    parameter int unsigned SRC_W      = 128,
    parameter int unsigned SRC_H      = 64,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned X_OFS      = 64,
    parameter int unsigned Y_OFS      = 112,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_en,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [7:0]            q_b,
`ifdef FB_SCANOUT_BORDER_EN
    input  logic [7:0]            border,
`endif
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [7:0]            pixel,
    output logic                  vblank,
    output logic                  frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HCNT_W  = cnt_width(H_TOTAL);
    localparam int unsigned VCNT_W  = cnt_width(V_TOTAL);
    localparam int unsigned WIN_W   = SRC_W << SCALE_LOG2;
    localparam int unsigned WIN_H   = SRC_H << SCALE_LOG2;
    localparam int unsigned SUB_W   = (SCALE_LOG2 == 0) ? 1 : SCALE_LOG2;

    localparam logic [SUB_W-1:0]      SUB_MAX   = SUB_W'((1 << SCALE_LOG2) - 1);
    localparam logic [HCNT_W-1:0]     H_LAST    = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0]     V_LAST    = VCNT_W'(V_TOTAL - 1);
    localparam logic [HCNT_W-1:0]     X_LO      = HCNT_W'(X_OFS);
    localparam logic [HCNT_W-1:0]     X_HI      = HCNT_W'(X_OFS + WIN_W);
    localparam logic [VCNT_W-1:0]     Y_LO      = VCNT_W'(Y_OFS);
    localparam logic [VCNT_W-1:0]     Y_HI      = VCNT_W'(Y_OFS + WIN_H);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(SRC_W);

    logic [HCNT_W-1:0]     w_h_cnt, w_h_next;
    logic [VCNT_W-1:0]     w_v_cnt, w_v_next;
    video_timing_t         w_timing;
    logic                  w_vblank, w_line_end, w_in_win, w_first;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_border;

    // Sub-counters tracking the source coordinate of the current counter position.
    logic [SUB_W-1:0]      r_x_sub, r_y_sub;
    logic [ADDR_WIDTH-1:0] r_sx, r_base;

    // Stage 1 / stage 2 pipeline registers.
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic                  r_win1, r_vblank1, r_first1;
    video_timing_t         r_tim1;
    logic                  r_hsync, r_vsync, r_de, r_vblank, r_frame_start;
    logic [7:0]            r_pixel;

    video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HCNT_W   (HCNT_W),
        .VCNT_W   (VCNT_W)
    ) u_timing (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_pix_en (pix_en),
        .o_h_cnt  (w_h_cnt),
        .o_v_cnt  (w_v_cnt),
        .o_timing (w_timing),
        .o_vblank (w_vblank)
    );

`ifdef FB_SCANOUT_BORDER_EN
    assign w_border = border;
`else
    assign w_border = 8'h00;
`endif

    always_comb begin
        w_line_end = (w_h_cnt == H_LAST);
        w_h_next   = w_line_end ? '0 : w_h_cnt + HCNT_W'(1);
        w_v_next   = (w_v_cnt == V_LAST) ? '0 : w_v_cnt + VCNT_W'(1);
        w_in_win   = (w_h_cnt >= X_LO) && (w_h_cnt < X_HI) &&
                     (w_v_cnt >= Y_LO) && (w_v_cnt < Y_HI);
        w_addr     = r_base + r_sx;
        w_first    = (w_h_cnt == '0) && (w_v_cnt == '0);
    end

    // Sub-counters are re-seeded on the tick that moves the counters onto the
    // window's first column/line, so their values outside the window are don't-care.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_sub <= '0;
            r_sx    <= '0;
            r_y_sub <= '0;
            r_base  <= '0;
        end else if (pix_en) begin
            if (w_h_next == X_LO) begin
                r_x_sub <= '0;
                r_sx    <= '0;
            end else if (r_x_sub == SUB_MAX) begin
                r_x_sub <= '0;
                r_sx    <= r_sx + ADDR_WIDTH'(1);
            end else begin
                r_x_sub <= r_x_sub + SUB_W'(1);
            end

            if (w_line_end) begin
                if (w_v_next == Y_LO) begin
                    r_y_sub <= '0;
                    r_base  <= '0;
                end else if (r_y_sub == SUB_MAX) begin
                    r_y_sub <= '0;
                    r_base  <= r_base + LINE_STEP;
                end else begin
                    r_y_sub <= r_y_sub + SUB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_b      <= '0;
            r_win1        <= 1'b0;
            r_tim1        <= TIMING_IDLE;
            r_vblank1     <= 1'b0;
            r_first1      <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
            r_pixel       <= 8'h00;
            r_vblank      <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            // Outside the window the address holds, so q_b stays quiet.
            if (w_in_win) begin
                r_addr_b <= w_addr;
            end
            r_win1    <= w_in_win;
            r_tim1    <= w_timing;
            r_vblank1 <= w_vblank;
            r_first1  <= w_first;

            r_hsync       <= r_tim1.hsync;
            r_vsync       <= r_tim1.vsync;
            r_de          <= r_tim1.de;
            r_vblank      <= r_vblank1;
            r_frame_start <= r_first1;
            if (!r_tim1.de) begin
                r_pixel <= 8'h00;
            end else if (r_win1) begin
                r_pixel <= q_b;
            end else begin
                r_pixel <= w_border;
            end
        end
    end

    assign addr_b      = r_addr_b;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign pixel       = r_pixel;
    assign vblank      = r_vblank;
    assign frame_start = r_frame_start;

endmodule
